// File: rtl/ym6045c_pkg.sv
// ---------------------------------------------------------------------------
// ym6045c_pkg: shared FSM states, owner codes and parameter defaults.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ym6045c_pkg;

  typedef enum logic [2:0] {
    Z_OWN = 3'd0,
    Z_REQ = 3'd1,
    M_OWN = 3'd2,
    B_REQ = 3'd3,
    B_OWN = 3'd4,
    B_REL = 3'd5
  } state_t;

  localparam logic [1:0] OWN_Z80   = 2'd0;
  localparam logic [1:0] OWN_M68K  = 2'd1;
  localparam logic [1:0] OWN_ZBANK = 2'd2;

  localparam int DEF_BANK_W   = 9;
  localparam int DEF_WAIT_CYC = 4;

endpackage

`default_nettype wire

// File: rtl/ym6045c_bank_sr.sv
// ---------------------------------------------------------------------------
// ym6045c_bank_sr: serial-load bank register, new bit enters at the MSB.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ym6045c_bank_sr
  import ym6045c_pkg::*;
#(
  parameter int BANK_W = DEF_BANK_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic              d,
  output logic [BANK_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (wr) begin
      q <= {d, q[BANK_W-1:1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/ym6045c_zbus_arbiter.sv
// ---------------------------------------------------------------------------
// ym6045c_zbus_arbiter: Z80/68K bus ownership FSM with bank-window hold timer.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ym6045c_zbus_arbiter
  import ym6045c_pkg::*;
#(
  parameter int BANK_W   = DEF_BANK_W,
  parameter int WAIT_CYC = DEF_WAIT_CYC
) (
  input  logic              CLK,
  input  logic              RES_n,
  input  logic              m68k_busreq,
  input  logic              z_busack_n,
  input  logic              win_req,
  input  logic              z_bank_req,
  input  logic              m68k_bg_n,
  input  logic              bank_wr,
  input  logic              bank_d,
  output logic              z_busreq_n,
  output logic              m68k_br_n,
  output logic              m68k_bgack_n,
  output logic              win_ack,
  output logic              z_wait_n,
  output logic [BANK_W-1:0] bank,
  output logic [1:0]        owner
);

  localparam logic [2:0] CNT_LOAD = 3'(WAIT_CYC);

  state_t     state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic       run;
  logic       win_armed, win_armed_nx;
  logic       bank_armed, bank_armed_nx;
  logic       ack_nx;
  logic       busreq_n_nx, br_n_nx, bgack_n_nx, wait_n_nx;
  logic [1:0] owner_nx;

  // run gates the FSM so the first transition lands on the second edge after reset release
  always_ff @(posedge CLK or negedge RES_n) begin
    if (!RES_n) begin
      run          <= 1'b0;
      state        <= Z_OWN;
      cnt          <= 3'd0;
      win_armed    <= 1'b1;
      bank_armed   <= 1'b1;
      z_busreq_n   <= 1'b1;
      m68k_br_n    <= 1'b1;
      m68k_bgack_n <= 1'b1;
      win_ack      <= 1'b0;
      z_wait_n     <= 1'b1;
      owner        <= OWN_Z80;
    end else begin
      run <= 1'b1;
      if (run) begin
        state        <= state_nx;
        cnt          <= cnt_nx;
        win_armed    <= win_armed_nx;
        bank_armed   <= bank_armed_nx;
        z_busreq_n   <= busreq_n_nx;
        m68k_br_n    <= br_n_nx;
        m68k_bgack_n <= bgack_n_nx;
        win_ack      <= ack_nx;
        z_wait_n     <= wait_n_nx;
        owner        <= owner_nx;
      end
    end
  end

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    ack_nx        = 1'b0;
    win_armed_nx  = win_armed;
    bank_armed_nx = bank_armed;
    if (!win_req)    win_armed_nx  = 1'b1;
    if (!z_bank_req) bank_armed_nx = 1'b1;
    case (state)
      Z_OWN: begin
        if (z_bank_req && bank_armed) state_nx = B_REQ;
        else if (m68k_busreq)         state_nx = Z_REQ;
      end
      Z_REQ: begin
        if (!z_busack_n)       state_nx = M_OWN;
        else if (!m68k_busreq) state_nx = Z_OWN;
      end
      M_OWN: begin
        ack_nx = win_req && win_armed && !win_ack;
        if (ack_nx) win_armed_nx = 1'b0;
        if (!m68k_busreq && !ack_nx && !win_ack) state_nx = Z_OWN;
      end
      B_REQ: begin
        if (!m68k_bg_n) begin
          state_nx = B_OWN;
          cnt_nx   = CNT_LOAD;
        end
      end
      B_OWN: begin
        if (cnt != 3'd0) cnt_nx = cnt - 3'd1;
        // leave as the count reaches zero so the grant is held exactly WAIT_CYC cycles
        if (cnt <= 3'd1) state_nx = B_REL;
      end
      B_REL: begin
        state_nx = Z_OWN;
        if (z_bank_req) bank_armed_nx = 1'b0;
      end
      default: state_nx = Z_OWN;
    endcase
  end

  always_comb begin
    busreq_n_nx = 1'b1;
    br_n_nx     = 1'b1;
    bgack_n_nx  = 1'b1;
    wait_n_nx   = 1'b1;
    owner_nx    = OWN_Z80;
    case (state_nx)
      Z_REQ: busreq_n_nx = 1'b0;
      M_OWN: begin
        busreq_n_nx = 1'b0;
        owner_nx    = OWN_M68K;
      end
      B_REQ: begin
        br_n_nx   = 1'b0;
        wait_n_nx = 1'b0;
      end
      B_OWN: begin
        br_n_nx    = 1'b0;
        bgack_n_nx = 1'b0;
        wait_n_nx  = 1'b0;
        owner_nx   = OWN_ZBANK;
      end
      default: ;
    endcase
  end

  ym6045c_bank_sr #(
    .BANK_W (BANK_W)
  ) u_bank_sr (
    .clk   (CLK),
    .rst_n (RES_n),
    .wr    (bank_wr),
    .d     (bank_d),
    .q     (bank)
  );

endmodule

`default_nettype wire

// File: tb/tb_ym6045c_zbus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ym6045c_zbus_arbiter: directed self-checking bench for the Z-bus arbiter.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ym6045c_zbus_arbiter;

  // {z_busreq_n, m68k_br_n, m68k_bgack_n, win_ack, z_wait_n, owner[1:0]}
  localparam logic [6:0] O_IDLE     = 7'b1110100;
  localparam logic [6:0] O_ZREQ     = 7'b0110100;
  localparam logic [6:0] O_MOWN     = 7'b0110101;
  localparam logic [6:0] O_MOWN_ACK = 7'b0111101;
  localparam logic [6:0] O_BREQ     = 7'b1010000;
  localparam logic [6:0] O_BOWN     = 7'b1000010;

  logic       CLK = 1'b0;
  logic       RES_n = 1'b0;
  logic       m68k_busreq = 1'b0;
  logic       z_busack_n = 1'b1;
  logic       win_req = 1'b0;
  logic       z_bank_req = 1'b0;
  logic       m68k_bg_n = 1'b1;
  logic       bank_wr = 1'b0;
  logic       bank_d = 1'b0;
  logic       z_busreq_n, m68k_br_n, m68k_bgack_n, win_ack, z_wait_n;
  logic [8:0] bank;
  logic [1:0] owner;
  logic [6:0] outs;

  int checks = 0;
  int errors = 0;

  assign outs = {z_busreq_n, m68k_br_n, m68k_bgack_n, win_ack, z_wait_n, owner};

  always #5 CLK = ~CLK;

  ym6045c_zbus_arbiter #(
    .BANK_W   (9),
    .WAIT_CYC (4)
  ) dut (
    .CLK          (CLK),
    .RES_n        (RES_n),
    .m68k_busreq  (m68k_busreq),
    .z_busack_n   (z_busack_n),
    .win_req      (win_req),
    .z_bank_req   (z_bank_req),
    .m68k_bg_n    (m68k_bg_n),
    .bank_wr      (bank_wr),
    .bank_d       (bank_d),
    .z_busreq_n   (z_busreq_n),
    .m68k_br_n    (m68k_br_n),
    .m68k_bgack_n (m68k_bgack_n),
    .win_ack      (win_ack),
    .z_wait_n     (z_wait_n),
    .bank         (bank),
    .owner        (owner)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    bank_wr = 1'b1;
    bank_d  = 1'b1;
    tick(); tick();
    checks++;
    if (outs !== O_IDLE || bank !== 9'h000) begin
      errors++;
      $display("FAIL reset_values outs=%b bank=%h exp outs=%b bank=000", outs, bank, O_IDLE);
    end
    bank_wr = 1'b0;
    m68k_busreq = 1'b1;
    RES_n = 1'b1;
    tick();
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL reset_sync_hold outs=%b exp %b", outs, O_IDLE);
    end
    tick();
    checks++;
    if (outs !== O_ZREQ) begin
      errors++; $display("FAIL reset_first_change outs=%b exp %b", outs, O_ZREQ);
    end
    m68k_busreq = 1'b0;
    tick();
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL reset_zreq_abort outs=%b exp %b", outs, O_IDLE);
    end
  endtask

  task automatic test_busreq();
    m68k_busreq = 1'b1;
    tick();
    checks++;
    if (outs !== O_ZREQ) begin
      errors++; $display("FAIL busreq_assert outs=%b exp %b", outs, O_ZREQ);
    end
    tick(); tick();
    z_busack_n = 1'b0;
    tick();
    checks++;
    if (outs !== O_MOWN) begin
      errors++; $display("FAIL busack_to_mown outs=%b exp %b", outs, O_MOWN);
    end
    z_busack_n = 1'b1;
    tick();
    checks++;
    if (outs !== O_MOWN) begin
      errors++; $display("FAIL busack_release_ignored outs=%b exp %b", outs, O_MOWN);
    end
    m68k_busreq = 1'b0;
    tick();
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL busreq_drop outs=%b exp %b", outs, O_IDLE);
    end
  endtask

  task automatic test_window();
    int acks;
    acks = 0;
    win_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      acks += int'(win_ack);
    end
    m68k_busreq = 1'b1;
    tick();
    acks += int'(win_ack);
    z_busack_n = 1'b0;
    tick();
    acks += int'(win_ack);
    checks++;
    if (acks != 0 || outs !== O_MOWN) begin
      errors++; $display("FAIL win_no_ack_outside acks=%0d outs=%b exp 0 %b", acks, outs, O_MOWN);
    end
    tick();
    checks++;
    if (outs !== O_MOWN_ACK) begin
      errors++; $display("FAIL win_ack_first outs=%b exp %b", outs, O_MOWN_ACK);
    end
    acks = int'(win_ack);
    for (int i = 0; i < 4; i++) begin
      tick();
      acks += int'(win_ack);
    end
    checks++;
    if (acks != 1) begin
      errors++; $display("FAIL win_single_pulse acks=%0d exp 1", acks);
    end
    win_req = 1'b0;
    tick();
    checks++;
    if (outs !== O_MOWN) begin
      errors++; $display("FAIL win_req_low outs=%b exp %b", outs, O_MOWN);
    end
    win_req = 1'b1;
    tick();
    checks++;
    if (outs !== O_MOWN_ACK) begin
      errors++; $display("FAIL win_rearm outs=%b exp %b", outs, O_MOWN_ACK);
    end
    win_req = 1'b0;
    tick();
    m68k_busreq = 1'b0;
    z_busack_n = 1'b1;
    tick();
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL win_exit outs=%b exp %b", outs, O_IDLE);
    end
  endtask

  task automatic test_shift();
    logic [8:0] pat;
    pat = 9'h10D;
    for (int i = 0; i < 9; i++) begin
      bank_d  = pat[i];
      bank_wr = 1'b1;
      tick();
      bank_wr = 1'b0;
      if (i == 0) begin
        checks++;
        if (bank !== 9'h100) begin
          errors++; $display("FAIL shift_first bank=%h exp 100", bank);
        end
      end
    end
    checks++;
    if (bank !== 9'h10D) begin
      errors++; $display("FAIL shift_full bank=%h exp 10d", bank);
    end
    bank_d = 1'b0;
    tick(); tick();
    checks++;
    if (bank !== 9'h10D) begin
      errors++; $display("FAIL shift_hold bank=%h exp 10d", bank);
    end
  endtask

  task automatic test_bank();
    int low;
    bit done;
    z_bank_req = 1'b1;
    tick();
    checks++;
    if (outs !== O_BREQ) begin
      errors++; $display("FAIL bank_req outs=%b exp %b", outs, O_BREQ);
    end
    tick();
    checks++;
    if (outs !== O_BREQ) begin
      errors++; $display("FAIL bank_wait_grant outs=%b exp %b", outs, O_BREQ);
    end
    m68k_bg_n = 1'b0;
    tick();
    checks++;
    if (outs !== O_BOWN) begin
      errors++; $display("FAIL bank_own outs=%b exp %b", outs, O_BOWN);
    end
    low = 1;
    done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (outs === O_BOWN) low++;
      else begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done || outs !== O_IDLE) begin
      errors++; $display("FAIL bank_release_together done=%0d outs=%b exp 1 %b", done, outs, O_IDLE);
    end
    checks++;
    if (low != 4) begin
      errors++; $display("FAIL bank_hold_cycles got %0d exp 4", low);
    end
    m68k_bg_n = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL bank_no_restart outs=%b exp %b", outs, O_IDLE);
    end
  endtask

  task automatic test_reset_mid();
    z_bank_req = 1'b0;
    tick();
    z_bank_req = 1'b1;
    tick();
    checks++;
    if (outs !== O_BREQ) begin
      errors++; $display("FAIL bank_rearm outs=%b exp %b", outs, O_BREQ);
    end
    m68k_bg_n = 1'b0;
    tick(); tick();
    checks++;
    if (outs !== O_BOWN) begin
      errors++; $display("FAIL mid_in_bown outs=%b exp %b", outs, O_BOWN);
    end
    #2 RES_n = 1'b0;
    #1;
    checks++;
    if (outs !== O_IDLE || bank !== 9'h000) begin
      errors++;
      $display("FAIL async_reset_mid outs=%b bank=%h exp outs=%b bank=000", outs, bank, O_IDLE);
    end
    z_bank_req = 1'b0;
    m68k_bg_n  = 1'b1;
    tick(); tick();
    RES_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_contention();
    bit done, bad;
    m68k_busreq = 1'b1;
    z_bank_req  = 1'b1;
    tick();
    checks++;
    if (outs !== O_BREQ) begin
      errors++; $display("FAIL contend_bank_first outs=%b exp %b", outs, O_BREQ);
    end
    m68k_bg_n = 1'b0;
    done = 1'b0;
    bad  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (z_busreq_n !== 1'b1) bad = 1'b1;
      if (outs === O_IDLE) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done || bad) begin
      errors++; $display("FAIL contend_bank_completes done=%0d busreq_seen=%0d exp 1 0", done, bad);
    end
    m68k_bg_n = 1'b1;
    tick();
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL contend_zown_return outs=%b exp %b", outs, O_IDLE);
    end
    tick();
    checks++;
    if (outs !== O_ZREQ) begin
      errors++; $display("FAIL contend_busreq_after outs=%b exp %b", outs, O_ZREQ);
    end
    m68k_busreq = 1'b0;
    z_bank_req  = 1'b0;
    tick();
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL contend_idle outs=%b exp %b", outs, O_IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_busreq();
    test_window();
    test_shift();
    test_bank();
    test_reset_mid();
    test_contention();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
